// File: rtl/sample_write_arbiter_pkg.sv
// Shared constants for the sample write arbiter: sample width, busy counter
// width and the source-index width helper.
package sample_arb_pkg;

  localparam int SAMPLE_W = 24;
  localparam int BUSY_W   = 8;

  // Index width for n requesters; a lone requester still needs one bit.
  function automatic int src_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sample_write_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate req so ptr sits at bit 0, isolate
// the lowest set bit, rotate the one-hot result back into requester order.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic [N-1:0] w_rot;
  logic [N-1:0] w_lsb;

  always_comb begin
    w_rot = '0;
    for (int j = 0; j < N; j++) begin
      w_rot[j] = req[(j + int'(ptr)) % N];
    end
  end

  assign w_lsb = w_rot & (~w_rot + N'(1));

  always_comb begin
    gnt = '0;
    for (int j = 0; j < N; j++) begin
      gnt[(j + int'(ptr)) % N] = w_lsb[j];
    end
  end

endmodule

// File: rtl/sample_write_arbiter.sv
// Round-robin write arbiter sharing one sample holding register among N
// producers. Optional SAMPLE_ARB_HOLD_EN adds a hold input that freezes writes.
module sample_write_arbiter
  import sample_arb_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = SAMPLE_W
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef SAMPLE_ARB_HOLD_EN
  input  logic                  hold,
`endif
  input  logic [N-1:0]          req,
  input  logic [N*DATA_W-1:0]   data,
  output logic [N-1:0]          gnt,
  output logic                  reg_en,
  output logic [DATA_W-1:0]     reg_d,
  output logic [src_w(N)-1:0]   reg_src,
  output logic [BUSY_W-1:0]     busy_cnt
);

  localparam int SRC_W = src_w(N);

  logic [SRC_W-1:0]  r_ptr;
  logic              r_en;
  logic [DATA_W-1:0] r_d;
  logic [SRC_W-1:0]  r_src;
  logic [BUSY_W-1:0] r_busy;

  logic [N-1:0]      w_pick;
  logic              w_stall;
  logic              w_any;
  logic [SRC_W-1:0]  w_idx;
  logic [SRC_W-1:0]  w_ptr_nxt;

  rr_pick #(
    .N     (N),
    .PTR_W (SRC_W)
  ) u_pick (
    .req (req),
    .ptr (r_ptr),
    .gnt (w_pick)
  );

  // A grant in a reset cycle must not complete a handshake.
`ifdef SAMPLE_ARB_HOLD_EN
  assign w_stall = reset | hold;
`else
  assign w_stall = reset;
`endif

  assign gnt   = w_stall ? '0 : w_pick;
  assign w_any = |gnt;

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) w_idx = SRC_W'(i);
    end
  end

  assign w_ptr_nxt = (w_idx == SRC_W'(N - 1)) ? '0 : w_idx + SRC_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr  <= '0;
      r_en   <= 1'b0;
      r_d    <= '0;
      r_src  <= '0;
      r_busy <= '0;
    end else begin
      r_en <= w_any;
      if (w_any) begin
        r_ptr <= w_ptr_nxt;
        r_d   <= data[w_idx*DATA_W +: DATA_W];
        r_src <= w_idx;
      end
      if ((|req) && !w_any) begin
        if (r_busy != '1) r_busy <= r_busy + BUSY_W'(1);
      end else begin
        r_busy <= '0;
      end
    end
  end

  assign reg_en   = r_en;
  assign reg_d    = r_d;
  assign reg_src  = r_src;
  assign busy_cnt = r_busy;

endmodule

// File: tb/tb_sample_write_arbiter.sv
// Randomized and directed bench for sample_write_arbiter with an in-bench
// round-robin reference model; build with SAMPLE_ARB_HOLD_EN to cover hold.
module tb_sample_write_arbiter;

  localparam int N      = 4;
  localparam int DATA_W = 24;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [N-1:0]        req = '0;
  logic [N*DATA_W-1:0] data = '0;
  logic [N-1:0]        gnt;
  logic                reg_en;
  logic [DATA_W-1:0]   reg_d;
  logic [1:0]          reg_src;
  logic [7:0]          busy_cnt;
`ifdef SAMPLE_ARB_HOLD_EN
  logic                hold = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model state
  int m_ptr = 0;
  bit m_en = 1'b0;
  logic [DATA_W-1:0] m_d = '0;
  int m_src = 0;
  int m_busy = 0;

  sample_write_arbiter #(.N(N), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef SAMPLE_ARB_HOLD_EN
    .hold     (hold),
`endif
    .req      (req),
    .data     (data),
    .gnt      (gnt),
    .reg_en   (reg_en),
    .reg_d    (reg_d),
    .reg_src  (reg_src),
    .busy_cnt (busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner by the search rule: first requester at or after ptr, modulo N.
  function automatic int model_pick();
    if (reset) return -1;
`ifdef SAMPLE_ARB_HOLD_EN
    if (hold) return -1;
`endif
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    g = model_pick();
    if (reset) begin
      m_ptr  <= 0;
      m_en   <= 1'b0;
      m_d    <= '0;
      m_src  <= 0;
      m_busy <= 0;
    end else begin
      m_en <= (g >= 0);
      if (g >= 0) begin
        m_ptr <= (g + 1) % N;
        m_d   <= data[g*DATA_W +: DATA_W];
        m_src <= g;
      end
      if (req != 0 && g < 0) m_busy <= (m_busy < 255) ? m_busy + 1 : 255;
      else m_busy <= 0;
    end
  end

  always @(negedge clk) begin
    int g;
    logic [N-1:0] eg;
    if (chk_en) begin
      g = model_pick();
      eg = (g < 0) ? '0 : N'(1 << g);
      check("model_gnt", 32'(gnt), 32'(eg));
      check("model_reg_en", 32'(reg_en), 32'(m_en));
      check("model_reg_d", 32'(reg_d), 32'(m_d));
      check("model_reg_src", 32'(reg_src), 32'(m_src));
      check("model_busy_cnt", 32'(busy_cnt), 32'(m_busy));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input int v);
    data[i*DATA_W +: DATA_W] = DATA_W'(v);
  endtask

  initial begin
    int vals[3];
    vals[0] = 60; vals[1] = 40; vals[2] = 60;

    // Reset, then idle
    tick(); reset = 1'b1; req = '0; chk_en = 1'b1;
    tick(); tick();
    for (int c = 0; c < 5; c++) begin
      tick(); reset = 1'b0; req = '0;
      @(negedge clk);
      check("idle_gnt", 32'(gnt), 32'h0);
      check("idle_reg_en", 32'(reg_en), 32'h0);
      check("idle_reg_d", 32'(reg_d), 32'h0);
      check("idle_busy", 32'(busy_cnt), 32'h0);
    end

    // All four requesting: strict rotation
    tick();
    req = 4'hF;
    for (int i = 0; i < N; i++) set_data(i, 10 * (i + 1));
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      @(negedge clk);
      check("rr_gnt", 32'(gnt), 32'(1 << (c % 4)));
      if (c > 0) begin
        check("rr_reg_d", 32'(reg_d), 32'(10 * ((c - 1) % 4 + 1)));
        check("rr_reg_en", 32'(reg_en), 32'h1);
      end
    end
    tick(); req = '0;
    @(negedge clk);
    check("rr_last_d", 32'(reg_d), 32'd40);
    check("rr_last_src", 32'(reg_src), 32'd3);

    // Wrap: grant to 3 sends ptr to 0
    tick(); req = 4'b1000;
    @(negedge clk);
    check("wrap_gnt3", 32'(gnt), 32'b1000);
    tick(); req = 4'b1001;
    @(negedge clk);
    check("wrap_gnt0", 32'(gnt), 32'b0001);
    tick(); req = '0;
    @(negedge clk);
    check("wrap_src", 32'(reg_src), 32'd0);
    check("wrap_en", 32'(reg_en), 32'd1);

    // Single requester held, changing data
    for (int k = 0; k < 3; k++) begin
      tick(); req = 4'b0100; set_data(2, vals[k]);
      @(negedge clk);
      check("single_gnt", 32'(gnt), 32'b0100);
      if (k > 0) check("single_reg_d", 32'(reg_d), 32'(vals[k - 1]));
    end
    tick(); req = '0;
    @(negedge clk);
    check("single_last_d", 32'(reg_d), 32'd60);
    check("single_src", 32'(reg_src), 32'd2);

    // Reset mid-stream
    tick(); req = 4'hF;
    tick();
    tick(); reset = 1'b1;
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    tick(); reset = 1'b0;
    @(negedge clk);
    check("rst_reg_en", 32'(reg_en), 32'h0);
    check("rst_reg_d", 32'(reg_d), 32'h0);
    check("rst_first_gnt", 32'(gnt), 32'b0001);
    tick(); req = '0;
    @(negedge clk);
    check("rst_after_d", 32'(reg_d), 32'd10);

`ifdef SAMPLE_ARB_HOLD_EN
    // Hold freezes arbitration; ptr sits at 1
    tick(); req = 4'b0011; hold = 1'b1;
    @(negedge clk);
    check("hold_gnt", 32'(gnt), 32'h0);
    check("hold_busy", 32'(busy_cnt), 32'd0);
    for (int k = 1; k < 3; k++) begin
      tick();
      @(negedge clk);
      check("hold_gnt", 32'(gnt), 32'h0);
      check("hold_busy", 32'(busy_cnt), 32'(k));
    end
    tick(); hold = 1'b0;
    @(negedge clk);
    check("hold_busy3", 32'(busy_cnt), 32'd3);
    check("hold_resume_gnt", 32'(gnt), 32'b0010);
    check("hold_reg_en", 32'(reg_en), 32'd0);
    tick(); req = '0;
    @(negedge clk);
    check("hold_busy_clr", 32'(busy_cnt), 32'd0);
    check("hold_src", 32'(reg_src), 32'd1);
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      tick();
      reset = ($urandom_range(63) == 0);
      req = N'($urandom);
      for (int i = 0; i < N; i++) set_data(i, int'($urandom_range(32'hFFFFFF)));
`ifdef SAMPLE_ARB_HOLD_EN
      hold = ($urandom_range(7) == 0);
`endif
    end
    tick();
    reset = 1'b0; req = '0;
    @(negedge clk);
    tick();
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
